wb_bus_arbiter_2m: RTL

- Two-master round-robin arbiter in front of the FPGA IP Wishbone slave bus (address decode, submodules).
- Master 0 is the AHB-to-FPGA bridge; master 1 is an internal fabric master such as a GPIO sequencer or DMA.
- Grants the shared bus for a whole CYC, routes ACK and read data back to the owner only, and steers address, data and strobes to the slave side.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_arb_timeout.sv | 43 ++++
 rtl/wb_bus_arbiter_2m.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Read data returned to the owner when a stalled transfer is aborted.
    localparam logic [31:0] ARB_DEFAULT_READ_VALUE = 32'hBADFABAC;

    function automatic logic [1:0] gnt_of_state(input arb_state_e st);
        case (st)
            ST_OWN0: return GNT_M0;
            ST_OWN1: return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts owner cycles with STB high and no slave ACK, pulses abort.
// Latency: abort is combinational in the cycle the count has reached TIMEOUT_CYCLES.
// Backpressure: none; a slave ACK or a dropped STB restarts the count.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_CNT_W  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,     // S_CYC & raw STB & !S_ACK
    input  logic clr_i,       // arbiter state is changing this edge
    output logic abort_o,
    output logic timeout_o
);

    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
    logic                     to_q, to_d;

    // A real slave ACK in the terminal cycle removes the stall, so it wins over the abort.
    assign abort_o   = stall_i && (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES));
    assign timeout_o = to_q;

    // Next count: restart on any break in the stall, on ownership change, or after an abort.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        to_d  = to_q | abort_o;
        if (clr_i || !stall_i || abort_o) begin
            cnt_d = '0;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; owner holds the bus for its whole CYC. Optional macro: WB_ARB_TIMEOUT_EN.
// Latency: grant one cycle after CYC is sampled in IDLE; slave mux and ACK return are combinational.
// Backpressure: no preemption; the waiting master stalls until the owner drops CYC.
module wb_bus_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int              ADR_W              = 17,
    parameter int              DAT_W              = 32,
    parameter int              TIMEOUT_CYCLES     = 255,
    parameter int              TIMEOUT_CNT_W      = 8,
    parameter logic [DAT_W-1:0] DEFAULT_READ_VALUE = DAT_W'(ARB_DEFAULT_READ_VALUE)
) (
    input  logic             WBs_CLK_i,
    input  logic             WBs_RST_i,
    input  logic             M0_CYC_i,
    input  logic             M0_STB_i,
    input  logic             M0_WE_i,
    input  logic [3:0]       M0_BYTE_STB_i,
    input  logic [ADR_W-1:0] M0_ADR_i,
    input  logic [DAT_W-1:0] M0_DAT_i,
    output logic [DAT_W-1:0] M0_DAT_o,
    output logic             M0_ACK_o,
    input  logic             M1_CYC_i,
    input  logic             M1_STB_i,
    input  logic             M1_WE_i,
    input  logic [3:0]       M1_BYTE_STB_i,
    input  logic [ADR_W-1:0] M1_ADR_i,
    input  logic [DAT_W-1:0] M1_DAT_i,
    output logic [DAT_W-1:0] M1_DAT_o,
    output logic             M1_ACK_o,
    output logic             S_CYC_o,
    output logic             S_STB_o,
    output logic             S_WE_o,
    output logic [3:0]       S_BYTE_STB_o,
    output logic [ADR_W-1:0] S_ADR_o,
    output logic [DAT_W-1:0] S_DAT_o,
    input  logic [DAT_W-1:0] S_DAT_i,
    input  logic             S_ACK_i,
    output logic [1:0]       GNT_o,
    output logic             TIMEOUT_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // 0 = M0 served last, 1 = M1 served last
    logic       s_stb_raw;
    logic       abort;

    // Ownership FSM: round-robin on ties, direct hand-over on release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_CYC_i && M1_CYC_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (M0_CYC_i) begin
                    state_d = ST_OWN0;
                end else if (M1_CYC_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!M0_CYC_i) begin
                    last_d  = 1'b0;
                    state_d = M1_CYC_i ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!M1_CYC_i) begin
                    last_d  = 1'b1;
                    state_d = M0_CYC_i ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and last-served registers; M0 wins the first tie after reset.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign GNT_o = gnt_of_state(state_q);

    // Steer the owner's request onto the slave side; IDLE drives all zeros.
    always_comb begin
        S_CYC_o      = 1'b0;
        s_stb_raw    = 1'b0;
        S_WE_o       = 1'b0;
        S_BYTE_STB_o = '0;
        S_ADR_o      = '0;
        S_DAT_o      = '0;
        case (state_q)
            ST_OWN0: begin
                S_CYC_o      = M0_CYC_i;
                s_stb_raw    = M0_STB_i;
                S_WE_o       = M0_WE_i;
                S_BYTE_STB_o = M0_BYTE_STB_i;
                S_ADR_o      = M0_ADR_i;
                S_DAT_o      = M0_DAT_i;
            end
            ST_OWN1: begin
                S_CYC_o      = M1_CYC_i;
                s_stb_raw    = M1_STB_i;
                S_WE_o       = M1_WE_i;
                S_BYTE_STB_o = M1_BYTE_STB_i;
                S_ADR_o      = M1_ADR_i;
                S_DAT_o      = M1_DAT_i;
            end
            default: ;
        endcase
    end

    // Aborted strobe is withdrawn from the slave in the abort cycle.
    assign S_STB_o = s_stb_raw & ~abort;

    // ACK goes to the owner only; read data is broadcast and qualified by ACK.
    assign M0_ACK_o = (state_q == ST_OWN0) & (S_ACK_i | abort);
    assign M1_ACK_o = (state_q == ST_OWN1) & (S_ACK_i | abort);
    assign M0_DAT_o = abort ? DEFAULT_READ_VALUE : S_DAT_i;
    assign M1_DAT_o = abort ? DEFAULT_READ_VALUE : S_DAT_i;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_CNT_W  (TIMEOUT_CNT_W)
    ) u_timeout (
        .clk_i     (WBs_CLK_i),
        .rst_i     (WBs_RST_i),
        .stall_i   (S_CYC_o & s_stb_raw & ~S_ACK_i),
        .clr_i     (state_d != state_q),
        .abort_o   (abort),
        .timeout_o (TIMEOUT_o)
    );
`else
    // Without the watchdog a stalled slave holds the owner forever.
    logic cfg_unused;
    assign cfg_unused = (TIMEOUT_CYCLES != 0) ^ (TIMEOUT_CNT_W != 0) ^ DEFAULT_READ_VALUE[0];
    assign abort      = 1'b0;
    assign TIMEOUT_o  = 1'b0;
`endif

endmodule
